// File: rtl/m_rv32.sv
// Shared RV32 constants and types used by the cache-side memory port arbiter.
package m_rv32;

    localparam int XLEN               = 32;
    localparam int PHYSICAL_ADDR_BITS = 32;
    localparam int MEM_PKT_BEATS      = 4;
    localparam int ARB_NREQ           = 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST,
        WR_WAIT
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundles of the memory port arbiter.
interface mem_req_if;
    import m_rv32::*;

    logic [ARB_NREQ-1:0][PHYSICAL_ADDR_BITS-1:0] s_addr;
    logic [ARB_NREQ-1:0]                         s_mr;
    logic [ARB_NREQ-1:0]                         s_mw;
    logic [ARB_NREQ-1:0][XLEN-1:0]               s_wword;
    logic [ARB_NREQ-1:0]                         s_ready;
    logic [XLEN-1:0]                             s_rword;

    modport master (output s_addr, s_mr, s_mw, s_wword, input s_ready, s_rword);
    modport slave  (input s_addr, s_mr, s_mw, s_wword, output s_ready, s_rword);
endinterface

interface mem_bus_if;
    import m_rv32::*;

    logic [PHYSICAL_ADDR_BITS-1:0] m_addr;
    logic                          m_rd;
    logic                          m_wr;
    logic [XLEN-1:0]               m_wword;
    logic                          m_ready;
    logic [XLEN-1:0]               m_rword;

    modport master (output m_addr, m_rd, m_wr, m_wword, input m_ready, m_rword);
    modport slave  (input m_addr, m_rd, m_wr, m_wword, output m_ready, m_rword);
endinterface

// File: rtl/mem_req_slot.sv
// Per-requester command latch: address/type, 4-word write buffer with capture
// counter, and pend/wfull flags that decide when the port may be granted.
module mem_req_slot
    import m_rv32::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_mr,
    input  logic                          i_mw,
    input  logic [PHYSICAL_ADDR_BITS-1:0] i_addr,
    input  logic [XLEN-1:0]               i_wword,
    input  logic                          i_clear,
    input  logic [1:0]                    i_sel,
    output logic                          o_eligible,
    output logic                          o_isWrite,
    output logic [PHYSICAL_ADDR_BITS-1:0] o_addr,
    output logic [XLEN-1:0]               o_word
);

    logic                          r_pend;
    logic                          r_isWrite;
    logic                          r_wfull;
    logic                          r_capActive;
    logic [1:0]                    r_capCnt;
    logic [PHYSICAL_ADDR_BITS-1:0] r_addr;
    logic [XLEN-1:0]               r_buf [MEM_PKT_BEATS];
    logic                          w_accept;

    // A completing packet frees the slot in the same cycle, so a new pulse then is still taken.
    assign w_accept = (i_mr | i_mw) & (~r_pend | i_clear);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_isWrite   <= 1'b0;
            r_wfull     <= 1'b0;
            r_capActive <= 1'b0;
            r_capCnt    <= 2'd0;
            r_addr      <= '0;
            for (int i = 0; i < MEM_PKT_BEATS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_accept) begin
            r_pend    <= 1'b1;
            r_isWrite <= i_mw;
            r_addr    <= i_addr;
            r_wfull   <= 1'b0;
            if (i_mw) begin
                r_buf[0]    <= i_wword;
                r_capActive <= 1'b1;
                r_capCnt    <= 2'd1;
            end else begin
                r_capActive <= 1'b0;
                r_capCnt    <= 2'd0;
            end
        end else begin
            if (i_clear) begin
                r_pend  <= 1'b0;
                r_wfull <= 1'b0;
            end
            if (r_capActive) begin
                r_buf[r_capCnt] <= i_wword;
                r_capCnt        <= r_capCnt + 2'd1;
                if (r_capCnt == 2'(MEM_PKT_BEATS - 1)) begin
                    r_capActive <= 1'b0;
                    r_wfull     <= 1'b1;
                end
            end
        end
    end

    assign o_eligible = r_pend & (~r_isWrite | r_wfull);
    assign o_isWrite  = r_isWrite;
    assign o_addr     = r_addr;
    assign o_word     = r_buf[i_sel];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: round-robin grant in IDLE, serialises
// 4-word packets onto the memory port and steers ready back to the owner.
module mem_port_arbiter
    import m_rv32::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_req_if.slave  i_req,
    mem_bus_if.master o_mem
);

    localparam int NREQ  = ARB_NREQ;
    localparam int BEATS = MEM_PKT_BEATS;

    arb_state_t                    r_state;
    arb_state_t                    w_nextState;
    logic                          r_ptr;
    logic                          r_owner;
    logic                          r_justReleased;
    logic [1:0]                    r_beat;
    logic [PHYSICAL_ADDR_BITS-1:0] r_mAddr;
    logic                          r_mRd;
    logic                          r_mWr;
    logic [XLEN-1:0]               r_mWword;

    logic [NREQ-1:0]               w_elig;
    logic [NREQ-1:0]               w_isWrite;
    logic [NREQ-1:0]               w_clear;
    logic [NREQ-1:0]               w_sReady;
    logic [PHYSICAL_ADDR_BITS-1:0] w_slotAddr [NREQ];
    logic [XLEN-1:0]               w_slotWord [NREQ];
    logic [1:0]                    w_beatSel;
    logic                          w_grant;
    logic                          w_grantPort;

    assign w_beatSel = (r_state == WR_BURST) ? r_beat : 2'd0;

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        mem_req_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .i_mr       (i_req.s_mr[g]),
            .i_mw       (i_req.s_mw[g]),
            .i_addr     (i_req.s_addr[g]),
            .i_wword    (i_req.s_wword[g]),
            .i_clear    (w_clear[g]),
            .i_sel      (w_beatSel),
            .o_eligible (w_elig[g]),
            .o_isWrite  (w_isWrite[g]),
            .o_addr     (w_slotAddr[g]),
            .o_word     (w_slotWord[g])
        );
    end

    // Right after a release, a contended grant goes to the other port regardless of the pointer.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_grantPort = r_ptr;
        w_clear     = '0;
        w_sReady    = '0;
        case (r_state)
            IDLE: begin
                if (w_elig != '0) begin
                    w_grant = 1'b1;
                    if (w_elig == 2'b11) begin
                        w_grantPort = r_justReleased ? ~r_owner : r_ptr;
                    end else begin
                        w_grantPort = w_elig[1];
                    end
                    w_nextState = w_isWrite[w_grantPort] ? WR_BURST : RD_WAIT;
                end
            end
            RD_WAIT: begin
                w_sReady[r_owner] = o_mem.m_ready;
                if (o_mem.m_ready) begin
                    w_nextState = RD_BURST;
                end
            end
            RD_BURST: begin
                if (r_beat == 2'(BEATS - 1)) begin
                    w_clear[r_owner] = 1'b1;
                    w_nextState      = IDLE;
                end
            end
            WR_BURST: begin
                if (r_beat == 2'(BEATS - 1)) begin
                    w_nextState = WR_WAIT;
                end
            end
            WR_WAIT: begin
                w_sReady[r_owner] = o_mem.m_ready;
                if (o_mem.m_ready) begin
                    w_clear[r_owner] = 1'b1;
                    w_nextState      = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_ptr          <= 1'b0;
            r_owner        <= 1'b0;
            r_justReleased <= 1'b0;
            r_beat         <= 2'd0;
            r_mAddr        <= '0;
            r_mRd          <= 1'b0;
            r_mWr          <= 1'b0;
            r_mWword       <= '0;
        end else begin
            r_state        <= w_nextState;
            r_mRd          <= 1'b0;
            r_mWr          <= 1'b0;
            r_justReleased <= (r_state != IDLE) && (w_nextState == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_grantPort;
                        r_mAddr <= w_slotAddr[w_grantPort];
                        if (w_elig == 2'b11) begin
                            r_ptr <= ~w_grantPort;
                        end
                        if (w_isWrite[w_grantPort]) begin
                            r_mWr    <= 1'b1;
                            r_mWword <= w_slotWord[w_grantPort];
                            r_beat   <= 2'd1;
                        end else begin
                            r_mRd  <= 1'b1;
                            r_beat <= 2'd0;
                        end
                    end
                end
                RD_WAIT: begin
                    if (o_mem.m_ready) begin
                        r_beat <= 2'd1;
                    end
                end
                RD_BURST: r_beat <= r_beat + 2'd1;
                WR_BURST: begin
                    r_mWword <= w_slotWord[r_owner];
                    r_beat   <= r_beat + 2'd1;
                end
                WR_WAIT: r_mWword <= '0;
                default: r_beat <= 2'd0;
            endcase
        end
    end

    assign o_mem.m_addr  = r_mAddr;
    assign o_mem.m_rd    = r_mRd;
    assign o_mem.m_wr    = r_mWr;
    assign o_mem.m_wword = r_mWword;
    assign i_req.s_ready = w_sReady;
    assign i_req.s_rword = o_mem.m_rword;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between two cache-side requesters: port 0 = data cache, port 1 = instruction cache or other fill agent.
- Requesters use the cache memory protocol unchanged and have no grant input:
  - read: one-cycle read pulse, then the first ready response carries word 0 and words 1-3 follow on consecutive cycles;
  - write: one-cycle write pulse carrying word 0, words 1-3 on the next 3 cycles, then wait for ready.
- The arbiter captures commands, buffers write packets, serialises 4-word packets onto the memory port, and steers ready and read data back to the owner.

Parameters:
- NREQ, 2, number of requester ports (fixed at 2; round-robin pointer is 1 bit)
- BEATS, 4, words per packet (fixed; beat counter is 2 bits)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- s_addr  in  NREQ x PHYSICAL_ADDR_BITS  requester packet address (word-aligned, bits [3:2] = 0 for packet start)
- s_mr  in  NREQ  requester read pulse
- s_mw  in  NREQ  requester write pulse (word 0 valid same cycle)
- s_wword  in  NREQ x XLEN  requester write word stream
- s_ready  out  NREQ  per-requester ready/completion
- s_rword  out  XLEN  read data broadcast to all requesters
- m_addr  out  PHYSICAL_ADDR_BITS  memory packet address
- m_rd  out  1  memory read pulse
- m_wr  out  1  memory write pulse (word 0 valid)
- m_wword  out  XLEN  memory write word stream
- m_ready  in  1  memory ready (read: word 0 valid; write: packet committed)
- m_rword  in  XLEN  memory read data

Behaviour:
- Reset:
  - all outputs 0;
  - pending flags, write buffers and beat counters cleared;
  - round-robin pointer = 0;
  - state = IDLE.
  - Reset mid-packet drops all pending and in-flight commands. Memory responses arriving after reset release are ignored, because state is IDLE.
- Capture, per port:
  - s_mr or s_mw latches the address, the type and pend = 1.
  - For a write, word 0 goes to buf[0]. Words 1-3 are captured on the next 3 cycles by the per-port capture counter, then wfull = 1.
  - s_mw and s_mr in the same cycle: the write wins.
  - A new pulse while pend = 1 is ignored, since the protocol allows one outstanding packet per port.
- Eligibility:
  - a read is eligible the cycle after capture;
  - a write is eligible the cycle after wfull is set (store-and-forward).
- Arbitration (in IDLE only):
  - one eligible port: it is granted;
  - both eligible: the port equal to the round-robin pointer wins, then the pointer moves to the other port.
- Grant cycle:
  - registered m_addr = owner address;
  - m_rd or m_wr high for exactly 1 cycle;
  - for a write, m_wword = buf[0].
  - Minimum read latency: s_mr at cycle t gives m_rd at t+2.
- State machine: IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT.
  - IDLE -> RD_WAIT on a read grant; IDLE -> WR_BURST on a write grant (beat = 1).
  - RD_WAIT:
    - s_ready[owner] = m_ready, combinational;
    - s_rword = m_rword, combinational, in all states;
    - on m_ready -> RD_BURST with beat = 1.
  - RD_BURST: the owner consumes m_rword without handshake. Exit to IDLE after beat 3; the owner's pend clears at that point.
  - WR_BURST: m_wword = buf[beat], beat increments, and beat 3 -> WR_WAIT.
  - WR_WAIT: s_ready[owner] = m_ready, combinational; on m_ready the owner's pend and wfull clear and the state -> IDLE.
- Other rules:
  - s_ready to a non-owner is always 0.
  - m_ready in IDLE, RD_BURST or WR_BURST is ignored.
  - A new capture on a port whose packet completes that same cycle is accepted, because capture has priority over clear.
  - The port just released may be re-granted in the next IDLE cycle only if the other port is not eligible.
  - No timeout: a stalled memory holds the port indefinitely.

Decomposition:
- PHYSICAL_ADDR_BITS and XLEN come from the shared m_rv32 package.
- Add to m_rv32:
  - MEM_PKT_BEATS = 4;
  - enum arb_state_t {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT}.
- One sub-module, mem_req_slot, instantiated per port. It holds the command latch, 4-word write buffer, capture counter, pend/wfull flags and eligibility output. The top level holds the FSM, pointer, beat counter and steering.

Test Plan:
- Idle read, port 0 only: s_mr[0] at t, addr 0x1000 -> m_rd at t+2 with m_addr 0x1000. Memory m_ready with words 0xA0..0xA3 -> s_ready[0] high 1 cycle with s_rword 0xA0, then 0xA1-0xA3 on the next cycles; s_ready[1] stays 0.
- Write store-and-forward, port 1: s_mw[1] with words 0x11,0x22,0x33,0x44 at t..t+3 -> m_wr at t+5, m_wword 0x11..0x44 over t+5..t+8. m_ready at t+12 -> s_ready[1] at t+12 only.
- Simultaneous reads on both ports after reset -> port 0 served first. Port 1's m_rd follows the cycle after port 0's burst ends. Repeat with both pending again -> port 1 first.
- Port 0 read pending during a port 1 write burst -> no m_rd until WR_WAIT receives m_ready. Port 0 sees no s_ready before its own m_ready.
- Assert rst during RD_BURST beat 2 -> all outputs 0 and both pends cleared. A stray m_ready after release produces no s_ready.
- Duplicate s_mr[0] while pending, plus simultaneous s_mr and s_mw on port 1 -> exactly one m_rd for port 0, and port 1 produces a write packet.
